// File: rtl/ps2_kbd_pkg.sv
// Shared constants, FSM state type and event entry layout for the PS/2 key decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_E0    = 8'hE0;
  localparam logic [7:0] PS2_F0    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Keyboard status/protocol bytes that never form key events
  localparam logic [7:0] SC_NUL = 8'h00;
  localparam logic [7:0] SC_ERR = 8'hFF;
  localparam logic [7:0] SC_BAT = 8'hAA;
  localparam logic [7:0] SC_ACK = 8'hFA;

  localparam int unsigned ENTRY_W = 18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic [7:0] code;
  } ev_entry_t;

  function automatic logic is_discard(input logic [7:0] c);
    return (c == SC_NUL) || (c == SC_ERR) || (c == SC_BAT) || (c == SC_ACK);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-event pop interface.
//   master (decoder): drives ev_valid/ev_code/ev_ext/ev_break/ev_ascii, reads ev_rd
//   slave (consumer): drives ev_rd, reads the head-event fields
interface ps2_key_decoder_if;
  logic       ev_rd;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;

  modport master (input ev_rd, output ev_valid, ev_code, ev_ext, ev_break, ev_ascii);
  modport slave  (output ev_rd, input ev_valid, ev_code, ev_ext, ev_break, ev_ascii);
endinterface

// File: rtl/ps2_key_decoder_ascii.sv
// scancode_to_ascii: combinational set-2 make-code to ASCII lookup.
//   code  : scan code (prefixes already stripped)
//   upper : select upper-case for letters
//   ascii : ASCII character, 0x00 when the code has no mapping
module scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] other;

  always_comb begin
    letter = 8'h00;
    other  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      8'h45: other = 8'h30;   8'h16: other = 8'h31;   8'h1E: other = 8'h32;
      8'h26: other = 8'h33;   8'h25: other = 8'h34;   8'h2E: other = 8'h35;
      8'h36: other = 8'h36;   8'h3D: other = 8'h37;   8'h3E: other = 8'h38;
      8'h46: other = 8'h39;
      8'h29: other = 8'h20;   8'h5A: other = 8'h0D;   8'h66: other = 8'h08;
      default: begin
        letter = 8'h00;
        other  = 8'h00;
      end
    endcase
  end

  // Clearing bit 5 maps a lower-case letter to its upper-case form
  assign ascii = (letter != 8'h00) ? (upper ? (letter & 8'hDF) : letter) : other;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns the PS/2 receiver byte stream into buffered key events.
//   clk, rst            : system clock, synchronous active-high reset
//   ps2_code, ps2_ready : receiver byte and its (asynchronous) ready level
//   ev                  : show-ahead event FIFO head and pop strobe
//   shift_held, ctrl_held, caps_lock : modifier state
//   overflow            : sticky, an event was dropped on a full FIFO
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          ps2_code,
  input  logic                ps2_ready,
  ps2_key_decoder_if.master   ev,
  output logic                shift_held,
  output logic                ctrl_held,
  output logic                caps_lock,
  output logic                overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Synchroniser and registered byte strobe
  logic       sync1, sync2, sync3;
  logic       byte_stb;
  logic [7:0] byte_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync3     <= 1'b1;
      byte_stb  <= 1'b0;
      byte_code <= 8'h00;
    end else begin
      sync1     <= ps2_ready;
      sync2     <= sync1;
      sync3     <= sync2;
      byte_stb  <= sync2 & ~sync3;
      byte_code <= ps2_code;
    end
  end

  // Prefix timeout counter, only runs while a prefix is pending
  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_c;

  assign tmo_c = (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || byte_stb || (state == S_IDLE)) begin
      tmo_cnt <= '0;
    end else if (!tmo_c) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Prefix FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Prefix FSM: next state and event emission
  logic emit_c, ext_c, brk_c;

  always_comb begin
    state_nxt = state;
    emit_c    = 1'b0;
    ext_c     = 1'b0;
    brk_c     = 1'b0;
    if (byte_stb) begin
      if (byte_code == PS2_E0) begin
        state_nxt = S_E0;
      end else if (byte_code == PS2_F0) begin
        case (state)
          S_IDLE:  state_nxt = S_F0;
          S_E0:    state_nxt = S_E0F0;
          default: state_nxt = state;
        endcase
      end else if (is_discard(byte_code)) begin
        state_nxt = S_IDLE;
      end else begin
        emit_c    = 1'b1;
        ext_c     = (state == S_E0) || (state == S_E0F0);
        brk_c     = (state == S_F0) || (state == S_E0F0);
        state_nxt = S_IDLE;
      end
    end else if ((state != S_IDLE) && tmo_c) begin
      state_nxt = S_IDLE;
    end
  end

  // Modifier tracking; left/right keys kept separately so releasing one keeps the other
  logic lshift, rshift, lctrl, rctrl, caps_held;
  logic lshift_n, rshift_n, lctrl_n, rctrl_n, caps_held_n, caps_lock_n;

  always_comb begin
    lshift_n    = lshift;
    rshift_n    = rshift;
    lctrl_n     = lctrl;
    rctrl_n     = rctrl;
    caps_held_n = caps_held;
    caps_lock_n = caps_lock;
    if (emit_c && !ext_c) begin
      case (byte_code)
        SC_LSHIFT: lshift_n = ~brk_c;
        SC_RSHIFT: rshift_n = ~brk_c;
        SC_CTRL:   lctrl_n  = ~brk_c;
        SC_CAPS: begin
          caps_held_n = ~brk_c;
          // Auto-repeat makes arrive with caps_held set and must not re-toggle
          if (!brk_c && !caps_held) caps_lock_n = ~caps_lock;
        end
        default: ;
      endcase
    end else if (emit_c && ext_c && (byte_code == SC_CTRL)) begin
      rctrl_n = ~brk_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      lctrl      <= 1'b0;
      rctrl      <= 1'b0;
      caps_held  <= 1'b0;
      caps_lock  <= 1'b0;
      shift_held <= 1'b0;
      ctrl_held  <= 1'b0;
    end else begin
      lshift     <= lshift_n;
      rshift     <= rshift_n;
      lctrl      <= lctrl_n;
      rctrl      <= rctrl_n;
      caps_held  <= caps_held_n;
      caps_lock  <= caps_lock_n;
      shift_held <= lshift_n | rshift_n;
      ctrl_held  <= lctrl_n | rctrl_n;
    end
  end

  // ASCII uses the modifier state from before this event
  logic [7:0] lut_ascii;
  ev_entry_t  push_data;

  scancode_to_ascii u_lut (
    .code  (byte_code),
    .upper (shift_held ^ caps_lock),
    .ascii (lut_ascii)
  );

  assign push_data = '{ext:   ext_c,
                       brk:   brk_c,
                       ascii: (ext_c || brk_c) ? 8'h00 : lut_ascii,
                       code:  byte_code};

  // Event FIFO with registered head so ev_* hold their last value when drained
  ev_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             full_c, pop_c, push_c, drop_c;
  ev_entry_t        head_nxt;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign pop_c      = ev.ev_rd && (count != '0);
  assign push_c     = emit_c && (!full_c || pop_c);
  assign drop_c     = emit_c && full_c && !pop_c;
  assign rd_ptr_nxt = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c)      count_nxt = count + CNT_W'(1);
    else if (!push_c && pop_c) count_nxt = count - CNT_W'(1);
    // A write landing in the new head slot is not yet in mem, so forward it
    if (push_c && (wr_ptr == rd_ptr_nxt)) head_nxt = push_data;
    else                                  head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      ev.ev_valid <= 1'b0;
      ev.ev_code  <= 8'h00;
      ev.ev_ext   <= 1'b0;
      ev.ev_break <= 1'b0;
      ev.ev_ascii <= 8'h00;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      overflow    <= overflow | drop_c;
      ev.ev_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        ev.ev_code  <= head_nxt.code;
        ev.ev_ext   <= head_nxt.ext;
        ev.ev_break <= head_nxt.brk;
        ev.ev_ascii <= head_nxt.ascii;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed, table-driven bench for ps2_key_decoder plus hand-written corner sequences.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_code = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       shift_held, ctrl_held, caps_lock, overflow;

  int total = 0;
  int bad   = 0;

  ps2_key_decoder_if ev_if ();

  ps2_key_decoder #(.DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_code   (ps2_code),
    .ps2_ready  (ps2_ready),
    .ev         (ev_if),
    .shift_held (shift_held),
    .ctrl_held  (ctrl_held),
    .caps_lock  (caps_lock),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic       ext;
    logic       brk;
    logic [7:0] asc;
    logic       sh;
    logic       ct;
    logic       cp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [7:0] b, input logic ev, input logic ext,
                              input logic brk, input logic [7:0] asc,
                              input logic sh, input logic ct, input logic cp);
    vec_t v;
    v.b = b; v.ev = ev; v.ext = ext; v.brk = brk; v.asc = asc;
    v.sh = sh; v.ct = ct; v.cp = cp;
    return v;
  endfunction

  function automatic vec_t pfx(input logic [7:0] b, input logic sh, input logic ct,
                               input logic cp);
    return mk(b, 1'b0, 1'b0, 1'b0, 8'h00, sh, ct, cp);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] head();
    return {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_ascii, ev_if.ev_code};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_code  = b;
    ps2_ready = 1'b1;
    repeat (6) @(negedge clk);
    ps2_ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Byte whose event write coincides with an ev_rd pulse
  task automatic send_byte_pop(input logic [7:0] b);
    @(negedge clk);
    ps2_code  = b;
    ps2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ev_if.ev_rd = 1'b1;
    @(posedge clk);
    #1 ev_if.ev_rd = 1'b0;
    repeat (4) @(negedge clk);
    ps2_ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    ev_if.ev_rd = 1'b1;
    @(negedge clk);
    ev_if.ev_rd = 1'b0;
  endtask

  task automatic expect_ev(input string name, input logic [17:0] exp);
    chk({name, "_valid"}, 32'(ev_if.ev_valid), 32'd1);
    chk({name, "_head"}, 32'(head()), 32'(exp));
    pop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_if.ev_rd = 1'b0;

    // Plain, shift, caps, repeat, right shift
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h61, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 0, 1, 8'h00, 0, 0, 0));
    vt.push_back(mk(8'h12, 1, 0, 0, 8'h00, 1, 0, 0));
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h41, 1, 0, 0));
    vt.push_back(pfx(8'hF0, 1, 0, 0));
    vt.push_back(mk(8'h1C, 1, 0, 1, 8'h00, 1, 0, 0));
    vt.push_back(pfx(8'hF0, 1, 0, 0));
    vt.push_back(mk(8'h12, 1, 0, 1, 8'h00, 0, 0, 0));
    vt.push_back(mk(8'h58, 1, 0, 0, 8'h00, 0, 0, 1));
    vt.push_back(mk(8'h58, 1, 0, 0, 8'h00, 0, 0, 1));
    vt.push_back(pfx(8'hF0, 0, 0, 1));
    vt.push_back(mk(8'h58, 1, 0, 1, 8'h00, 0, 0, 1));
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h41, 0, 0, 1));
    vt.push_back(mk(8'h32, 1, 0, 0, 8'h42, 0, 0, 1));
    vt.push_back(mk(8'h12, 1, 0, 0, 8'h00, 1, 0, 1));
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h61, 1, 0, 1));
    vt.push_back(mk(8'h16, 1, 0, 0, 8'h31, 1, 0, 1));
    vt.push_back(pfx(8'hF0, 1, 0, 1));
    vt.push_back(mk(8'h12, 1, 0, 1, 8'h00, 0, 0, 1));
    vt.push_back(mk(8'h58, 1, 0, 0, 8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(mk(8'h58, 1, 0, 1, 8'h00, 0, 0, 0));
    vt.push_back(mk(8'h32, 1, 0, 0, 8'h62, 0, 0, 0));
    vt.push_back(mk(8'h59, 1, 0, 0, 8'h00, 1, 0, 0));
    vt.push_back(mk(8'h1A, 1, 0, 0, 8'h5A, 1, 0, 0));
    vt.push_back(pfx(8'hF0, 1, 0, 0));
    vt.push_back(mk(8'h59, 1, 0, 1, 8'h00, 0, 0, 0));
    // Extended keys and Ctrl
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(mk(8'h75, 1, 1, 0, 8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(mk(8'h75, 1, 1, 1, 8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(mk(8'h14, 1, 1, 0, 8'h00, 0, 1, 0));
    vt.push_back(pfx(8'hE0, 0, 1, 0));
    vt.push_back(mk(8'h12, 1, 1, 0, 8'h00, 0, 1, 0));
    vt.push_back(pfx(8'hE0, 0, 1, 0));
    vt.push_back(pfx(8'hF0, 0, 1, 0));
    vt.push_back(mk(8'h12, 1, 1, 1, 8'h00, 0, 1, 0));
    vt.push_back(pfx(8'hE0, 0, 1, 0));
    vt.push_back(pfx(8'hF0, 0, 1, 0));
    vt.push_back(mk(8'h14, 1, 1, 1, 8'h00, 0, 0, 0));
    vt.push_back(mk(8'h14, 1, 0, 0, 8'h00, 0, 1, 0));
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h61, 0, 1, 0));
    vt.push_back(pfx(8'hF0, 0, 1, 0));
    vt.push_back(mk(8'h14, 1, 0, 1, 8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 1, 0, 8'h00, 0, 0, 0));
    // Digits and specials
    vt.push_back(mk(8'h45, 1, 0, 0, 8'h30, 0, 0, 0));
    vt.push_back(mk(8'h46, 1, 0, 0, 8'h39, 0, 0, 0));
    vt.push_back(mk(8'h3D, 1, 0, 0, 8'h37, 0, 0, 0));
    vt.push_back(mk(8'h29, 1, 0, 0, 8'h20, 0, 0, 0));
    vt.push_back(mk(8'h5A, 1, 0, 0, 8'h0D, 0, 0, 0));
    vt.push_back(mk(8'h66, 1, 0, 0, 8'h08, 0, 0, 0));
    vt.push_back(mk(8'h76, 1, 0, 0, 8'h00, 0, 0, 0));
    // Discards, and prefix edge cases
    vt.push_back(pfx(8'hAA, 0, 0, 0));
    vt.push_back(pfx(8'hFA, 0, 0, 0));
    vt.push_back(pfx(8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hFF, 0, 0, 0));
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(pfx(8'hAA, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h61, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(pfx(8'h00, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 0, 0, 8'h61, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 0, 1, 8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 1, 1, 8'h00, 0, 0, 0));
    vt.push_back(pfx(8'hF0, 0, 0, 0));
    vt.push_back(pfx(8'hE0, 0, 0, 0));
    vt.push_back(mk(8'h1C, 1, 1, 0, 8'h00, 0, 0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        32'({ev_if.ev_valid, head(), shift_held, ctrl_held, caps_lock, overflow}), 32'd0);

    // First-event latency: ev_valid rises 3 edges after ready is first sampled high
    @(negedge clk);
    ps2_code  = 8'h1C;
    ps2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("latency_before", 32'(ev_if.ev_valid), 32'd0);
    @(posedge clk);
    #1 chk("latency_at", 32'(ev_if.ev_valid), 32'd1);
    repeat (3) @(negedge clk);
    ps2_ready = 1'b0;
    repeat (6) @(negedge clk);
    expect_ev("latency_ev", {1'b0, 1'b0, 8'h61, 8'h1C});
    chk("empty_after_pop", 32'(ev_if.ev_valid), 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      send_byte(vt[i].b);
      if (vt[i].ev) begin
        expect_ev($sformatf("vec%0d", i), {vt[i].ext, vt[i].brk, vt[i].asc, vt[i].b});
      end else begin
        chk($sformatf("vec%0d_noev", i), 32'(ev_if.ev_valid), 32'd0);
      end
      chk($sformatf("vec%0d_mods", i), 32'({shift_held, ctrl_held, caps_lock}),
          32'({vt[i].sh, vt[i].ct, vt[i].cp}));
    end

    // Overflow: fill, push+pop while full, then a dropped push
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'h21);
    send_byte(8'h23);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    chk("full_head", 32'(head()), 32'({1'b0, 1'b0, 8'h61, 8'h1C}));
    send_byte_pop(8'h24);
    chk("pushpop_no_ovf", 32'(overflow), 32'd0);
    chk("pushpop_head", 32'(head()), 32'({1'b0, 1'b0, 8'h62, 8'h32}));
    send_byte(8'h2B);
    chk("drop_ovf", 32'(overflow), 32'd1);
    expect_ev("drain0", {1'b0, 1'b0, 8'h62, 8'h32});
    expect_ev("drain1", {1'b0, 1'b0, 8'h63, 8'h21});
    expect_ev("drain2", {1'b0, 1'b0, 8'h64, 8'h23});
    expect_ev("drain3", {1'b0, 1'b0, 8'h65, 8'h24});
    chk("drained_empty", 32'(ev_if.ev_valid), 32'd0);
    chk("hold_last_code", 32'(ev_if.ev_code), 32'h24);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-prefix with modifiers set and an event queued
    send_byte(8'h58);
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'h14);
    send_byte(8'hE0);
    chk("pre_reset_mods", 32'({shift_held, ctrl_held, caps_lock}), 32'h7);
    do_reset();
    chk("mid_reset_outputs",
        32'({ev_if.ev_valid, head(), shift_held, ctrl_held, caps_lock, overflow}), 32'd0);
    send_byte(8'h1C);
    expect_ev("post_reset_ev", {1'b0, 1'b0, 8'h61, 8'h1C});

    // Ready already high when reset releases gives no strobe
    @(negedge clk);
    ps2_code  = 8'h1C;
    ps2_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("ready_thru_reset", 32'(ev_if.ev_valid), 32'd0);
    ps2_ready = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h1C);
    expect_ev("after_ready_reset", {1'b0, 1'b0, 8'h61, 8'h1C});

    // Prefix timeout: short idle keeps the break, long idle abandons it
    send_byte(8'hF0);
    repeat (TMO / 4) @(negedge clk);
    send_byte(8'h1C);
    expect_ev("tmo_short", {1'b0, 1'b1, 8'h00, 8'h1C});
    send_byte(8'hF0);
    repeat (TMO + 5) @(negedge clk);
    send_byte(8'h1C);
    expect_ev("tmo_long", {1'b0, 1'b0, 8'h61, 8'h1C});
    send_byte(8'hE0);
    repeat (TMO + 5) @(negedge clk);
    send_byte(8'h75);
    expect_ev("tmo_e0", {1'b0, 1'b0, 8'h00, 8'h75});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
